// File: rtl/bcsa_pkg.sv
// Shared constants for the block carry-select approximate adder.
package bcsa_pkg;

    // Default operand width and block size.
    localparam int unsigned WIDTH_DEF   = 32'd16;
    localparam int unsigned BLK_DEF     = 32'd4;
    localparam int unsigned NUM_BLK_DEF = WIDTH_DEF / BLK_DEF;

    // Number of carry-select blocks for a given operand width and block size.
    function automatic int unsigned blk_count(input int unsigned width, input int unsigned blk);
        return width / blk;
    endfunction

endpackage

// File: rtl/bcsa_block.sv
// One carry-select block: both candidate sums, for carry-in 0 and carry-in 1.
module bcsa_block
    import bcsa_pkg::*;
#(
    parameter int unsigned BLK = BLK_DEF
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    output logic [BLK-1:0] sum0,
    output logic [BLK-1:0] sum1,
    output logic           cout0,
    output logic           cout1
);

    logic [BLK:0] add0_s;
    logic [BLK:0] add1_s;

    // Form both candidate results in parallel; the carry-in selects later.
    always_comb begin
        add0_s = {1'b0, a} + {1'b0, b};
        add1_s = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
    end

    assign sum0  = add0_s[BLK-1:0];
    assign cout0 = add0_s[BLK];
    assign sum1  = add1_s[BLK-1:0];
    assign cout1 = add1_s[BLK];

endmodule

// File: rtl/bcsa_adder.sv
// Approximate block carry-select adder: each block above block 0 guesses its
// carry-in from the generate of the block below only, so the carry chain is
// one block long. The exact sum is also formed to flag a wrong guess.
module bcsa_adder
    import bcsa_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned BLK   = BLK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A_I,
    input  logic [WIDTH-1:0] B_I,
    input  logic             Co_Iin,
    output logic [WIDTH-1:0] S_I,
    output logic             Co_I,
    output logic             Err_I
);

    localparam int unsigned NUM_BLK = blk_count(WIDTH, BLK);

    logic [WIDTH-1:0]   sum0_s;
    logic [WIDTH-1:0]   sum1_s;
    logic [WIDTH-1:0]   sum_sel_s;
    logic [NUM_BLK-1:0] cout0_s;
    logic [NUM_BLK-1:0] cout1_s;
    logic [NUM_BLK-1:0] cin_s;
    logic [NUM_BLK-1:0] cout_sel_s;
    logic [WIDTH:0]     exact_s;
    logic               err_s;

    logic [WIDTH-1:0]   s_r;
    logic               co_r;
    logic               err_r;

    for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
        bcsa_block #(
            .BLK (BLK)
        ) u_block (
            .a     (A_I[k*BLK +: BLK]),
            .b     (B_I[k*BLK +: BLK]),
            .sum0  (sum0_s[k*BLK +: BLK]),
            .sum1  (sum1_s[k*BLK +: BLK]),
            .cout0 (cout0_s[k]),
            .cout1 (cout1_s[k])
        );

        // Block 0 sees the true carry-in; higher blocks guess from the
        // generate of the block below.
        if (k == 0) begin : g_cin_exact
            assign cin_s[k] = Co_Iin;
        end else begin : g_cin_spec
            assign cin_s[k] = cout0_s[k-1];
        end

        assign sum_sel_s[k*BLK +: BLK] = cin_s[k] ? sum1_s[k*BLK +: BLK] : sum0_s[k*BLK +: BLK];
        assign cout_sel_s[k]           = cin_s[k] ? cout1_s[k] : cout0_s[k];
    end

    // Exact reference sum of the same sample and mismatch detection.
    always_comb begin
        exact_s = {1'b0, A_I} + {1'b0, B_I} + {{WIDTH{1'b0}}, Co_Iin};
        if ({cout_sel_s[NUM_BLK-1], sum_sel_s} != exact_s) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Output register; reset discards the sample of that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r   <= {WIDTH{1'b0}};
            co_r  <= 1'b0;
            err_r <= 1'b0;
        end else begin
            s_r   <= sum_sel_s;
            co_r  <= cout_sel_s[NUM_BLK-1];
            err_r <= err_s;
        end
    end

    assign S_I   = s_r;
    assign Co_I  = co_r;
    assign Err_I = err_r;

endmodule

// File: tb/tb_bcsa_adder.sv
// Self-checking bench for bcsa_adder: directed vectors plus random operands
// against a block-wise arithmetic reference model.
module tb_bcsa_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned BLK   = 4;
    localparam int unsigned NBLK  = WIDTH / BLK;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             err;

    int n_checks;
    int n_errors;

    bcsa_adder #(
        .WIDTH (WIDTH),
        .BLK   (BLK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .A_I    (a),
        .B_I    (b),
        .Co_Iin (cin),
        .S_I    (s),
        .Co_I   (co),
        .Err_I  (err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: each block adds its operand nibbles plus a carry-in that is
    // Co_Iin for block 0 and, above it, the carry out of the lower block's
    // own operands alone. Returns {err, co, sum}.
    function automatic logic [WIDTH+1:0] model(input int unsigned av, input int unsigned bv,
                                               input int unsigned cv);
        int unsigned mask;
        int unsigned sum;
        int unsigned carry;
        int unsigned ci;
        int unsigned t;
        int unsigned exact;
        mask  = (1 << BLK) - 1;
        sum   = 0;
        carry = 0;
        for (int k = 0; k < NBLK; k++) begin
            if (k == 0) ci = cv;
            else ci = (((av >> ((k-1)*BLK)) & mask) + ((bv >> ((k-1)*BLK)) & mask)) >> BLK;
            t     = ((av >> (k*BLK)) & mask) + ((bv >> (k*BLK)) & mask) + ci;
            sum   = sum | ((t & mask) << (k*BLK));
            carry = t >> BLK;
        end
        exact = av + bv + cv;
        model = {((carry << WIDTH) | sum) != exact, carry[0], sum[WIDTH-1:0]};
    endfunction

    // Drive one sample away from the active edge, then sample results after it.
    task automatic apply(input logic r, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv);
        @(negedge clk);
        rst = r;
        a   = av;
        b   = bv;
        cin = cv;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [WIDTH-1:0] es, input logic eco,
                              input logic eerr);
        check_eq({tag, ".s"},   32'(s),   32'(es));
        check_eq({tag, ".co"},  32'(co),  32'(eco));
        check_eq({tag, ".err"}, 32'(err), 32'(eerr));
    endtask

    initial begin
        logic [WIDTH+1:0] m;
        logic [WIDTH:0]   exact;
        int unsigned      ra, rb, rc;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;

        // Reset for two cycles with all-ones operands.
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
            expect_out("reset", 16'h0000, 1'b0, 1'b0);
        end

        // Small sums, one per cycle.
        apply(1'b0, 16'd0, 16'd1, 1'b0); expect_out("seq0", 16'h0001, 1'b0, 1'b0);
        apply(1'b0, 16'd2, 16'd1, 1'b0); expect_out("seq1", 16'h0003, 1'b0, 1'b0);
        apply(1'b0, 16'd8, 16'd4, 1'b0); expect_out("seq2", 16'h000C, 1'b0, 1'b0);
        apply(1'b0, 16'd9, 16'd5, 1'b0); expect_out("seq3", 16'h000E, 1'b0, 1'b0);

        // Speculation boundaries.
        apply(1'b0, 16'h000F, 16'h0001, 1'b0); expect_out("spec_ok",   16'h0010, 1'b0, 1'b0);
        apply(1'b0, 16'h000F, 16'h0000, 1'b1); expect_out("spec_miss", 16'h0000, 1'b0, 1'b1);
        apply(1'b0, 16'hFFFF, 16'h0001, 1'b0); expect_out("wrap_miss", 16'hFF00, 1'b0, 1'b1);
        apply(1'b0, 16'hFFFF, 16'hFFFF, 1'b1); expect_out("all_ones",  16'hFFFF, 1'b1, 1'b0);

        // Mid-stream reset overrides the pending result.
        apply(1'b1, 16'h1234, 16'h4321, 1'b1); expect_out("mid_rst", 16'h0000, 1'b0, 1'b0);

        // Random back-to-back operands, with an occasional reset cycle.
        for (int i = 0; i < 400; i++) begin
            ra = $urandom_range(16'hFFFF, 0);
            rb = $urandom_range(16'hFFFF, 0);
            rc = $urandom_range(1, 0);
            if ($urandom_range(31, 0) == 0) begin
                apply(1'b1, ra[WIDTH-1:0], rb[WIDTH-1:0], rc[0]);
                expect_out("rand_rst", 16'h0000, 1'b0, 1'b0);
            end else begin
                m = model(ra, rb, rc);
                apply(1'b0, ra[WIDTH-1:0], rb[WIDTH-1:0], rc[0]);
                expect_out("rand", m[WIDTH-1:0], m[WIDTH], m[WIDTH+1]);
                if (err == 1'b0) begin
                    exact = 17'(ra + rb + rc);
                    check_eq("rand_exact", 32'({co, s}), 32'(exact));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
